// File: rtl/axi_intc_svc_pkg.sv
// Package for the interrupt-controller servicer.
// Holds register offsets, AXI response codes, the IVR "no interrupt" value,
// and the state encodings for the servicer FSM and the single-beat engine.
// Optional feature macro used by the top: AXI_INTC_SVC_STATS_EN.
package axi_intc_svc_pkg;

  localparam logic [8:0]  IER_ADDR  = 9'h008;
  localparam logic [8:0]  IAR_ADDR  = 9'h00C;
  localparam logic [8:0]  IVR_ADDR  = 9'h018;
  localparam logic [8:0]  MER_ADDR  = 9'h01C;

  localparam logic [1:0]  RESP_OKAY = 2'b00;

  // IVR reads back all ones when no enabled interrupt is pending.
  localparam logic [31:0] IVR_NONE  = 32'hFFFF_FFFF;

  // MER: master enable plus hardware interrupt enable.
  localparam logic [31:0] MER_VALUE = 32'h0000_0003;

  typedef enum logic [2:0] {
    ST_INIT_IER,
    ST_INIT_MER,
    ST_IDLE,
    ST_RD_IVR,
    ST_EMIT,
    ST_WR_IAR,
    ST_GUARD
  } svc_state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_WADDR,
    PH_WRESP,
    PH_RADDR,
    PH_RDATA
  } phase_t;

endpackage

// File: rtl/axi_lite_single_master.sv
// Single-beat AXI4-Lite initiator. Holds one transaction at a time.
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   req/req_write       : start a write (1) or read (0) while the engine is idle
//   req_addr/req_wdata  : address and write data, captured at start
//   done                : one-cycle strobe in the cycle the B or R beat is accepted
//   resp/rdata          : response code and read data, valid alongside done
//   m_axi_*             : AXI4-Lite master channels (all outputs registered)
module axi_lite_single_master
  import axi_intc_svc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_write,
  input  logic [8:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [1:0]  resp,
  output logic [31:0] rdata,
  output logic [8:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [8:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  phase_t      phase_reg;
  logic [8:0]  awaddr_reg, araddr_reg;
  logic [31:0] wdata_reg;
  logic        awvalid_reg, wvalid_reg, bready_reg, arvalid_reg, rready_reg;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = awvalid_reg && m_axi_awready;
  assign w_hs  = wvalid_reg  && m_axi_wready;
  assign b_hs  = bready_reg  && m_axi_bvalid;
  assign ar_hs = arvalid_reg && m_axi_arready;
  assign r_hs  = rready_reg  && m_axi_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg   <= PH_IDLE;
      awaddr_reg  <= '0;
      araddr_reg  <= '0;
      wdata_reg   <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
    end else begin
      case (phase_reg)
        PH_IDLE: begin
          if (req) begin
            if (req_write) begin
              awaddr_reg  <= req_addr;
              wdata_reg   <= req_wdata;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              phase_reg   <= PH_WADDR;
            end else begin
              araddr_reg  <= req_addr;
              arvalid_reg <= 1'b1;
              phase_reg   <= PH_RADDR;
            end
          end
        end
        PH_WADDR: begin
          if (aw_hs) awvalid_reg <= 1'b0;
          if (w_hs)  wvalid_reg  <= 1'b0;
          // Both channels accepted (earlier or on this edge): open the B channel.
          if ((aw_hs || !awvalid_reg) && (w_hs || !wvalid_reg)) begin
            bready_reg <= 1'b1;
            phase_reg  <= PH_WRESP;
          end
        end
        PH_WRESP: begin
          if (b_hs) begin
            bready_reg <= 1'b0;
            phase_reg  <= PH_IDLE;
          end
        end
        PH_RADDR: begin
          if (ar_hs) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            phase_reg   <= PH_RDATA;
          end
        end
        PH_RDATA: begin
          if (r_hs) begin
            rready_reg <= 1'b0;
            phase_reg  <= PH_IDLE;
          end
        end
        default: phase_reg <= PH_IDLE;
      endcase
    end
  end

  // bready is only ever high during a write response, so it selects the source.
  assign done  = b_hs || r_hs;
  assign resp  = bready_reg ? m_axi_bresp : m_axi_rresp;
  assign rdata = m_axi_rdata;

  assign m_axi_awaddr  = awaddr_reg;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_bready  = bready_reg;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_rready  = rready_reg;

endmodule

// File: rtl/axi_intc_servicer.sv
// Hardware interrupt servicer for the AXI interrupt controller.
// Programs IER and MER after reset, then for each level irq reads IVR,
// presents the decoded ID on a valid/ready event port and acknowledges
// through IAR, followed by a short guard interval.
// Ports:
//   processor_clk, processor_rst : clock, asynchronous active-high reset
//   m_axi_*                      : AXI4-Lite master to the controller's slave
//   irq                          : level interrupt input
//   evt_valid/evt_ready/evt_id   : serviced-interrupt handshake
//   init_done, busy, err         : status (err is sticky)
//   svc_count, spurious_count    : saturating counters, only when
//                                  AXI_INTC_SVC_STATS_EN is defined
module axi_intc_servicer
  import axi_intc_svc_pkg::*;
#(
  parameter logic [31:0] ENABLE_MASK  = 32'hFFFF_FFFF,
  parameter int          GUARD_CYCLES = 2
) (
  input  logic        processor_clk,
  input  logic        processor_rst,
  output logic [8:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [8:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic        irq,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [4:0]  evt_id,
  output logic        init_done,
  output logic        busy,
  output logic        err
`ifdef AXI_INTC_SVC_STATS_EN
  ,
  output logic [31:0] svc_count,
  output logic [31:0] spurious_count
`endif
);

  svc_state_t  state_reg, state_next;

  logic        eng_req, eng_write, eng_done;
  logic [8:0]  eng_addr;
  logic [31:0] eng_wdata, eng_rdata;
  logic [1:0]  eng_resp;

  logic        evt_valid_reg, init_done_reg, busy_reg, err_reg;
  logic [4:0]  evt_id_reg;
  logic [3:0]  guard_cnt_reg;
  logic        ivr_spurious;

  // A failed read is treated like "nothing pending": no event, no acknowledge.
  assign ivr_spurious = (eng_resp != RESP_OKAY) || (eng_rdata == IVR_NONE);

  axi_lite_single_master u_master (
    .clk           (processor_clk),
    .rst           (processor_rst),
    .req           (eng_req),
    .req_write     (eng_write),
    .req_addr      (eng_addr),
    .req_wdata     (eng_wdata),
    .done          (eng_done),
    .resp          (eng_resp),
    .rdata         (eng_rdata),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  always_ff @(posedge processor_clk or posedge processor_rst) begin
    if (processor_rst) state_reg <= ST_INIT_IER;
    else               state_reg <= state_next;
  end

  // Transaction states hold req high; the engine ignores it until idle and
  // finishes on the same edge the FSM leaves the state, so no re-issue.
  always_comb begin
    state_next = state_reg;
    eng_req    = 1'b0;
    eng_write  = 1'b0;
    eng_addr   = '0;
    eng_wdata  = '0;
    case (state_reg)
      ST_INIT_IER: begin
        eng_req   = 1'b1;
        eng_write = 1'b1;
        eng_addr  = IER_ADDR;
        eng_wdata = ENABLE_MASK;
        if (eng_done) state_next = ST_INIT_MER;
      end
      ST_INIT_MER: begin
        eng_req   = 1'b1;
        eng_write = 1'b1;
        eng_addr  = MER_ADDR;
        eng_wdata = MER_VALUE;
        if (eng_done) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (irq) state_next = ST_RD_IVR;
      end
      ST_RD_IVR: begin
        eng_req  = 1'b1;
        eng_addr = IVR_ADDR;
        if (eng_done) state_next = ivr_spurious ? ST_IDLE : ST_EMIT;
      end
      ST_EMIT: begin
        if (evt_valid_reg && evt_ready) state_next = ST_WR_IAR;
      end
      ST_WR_IAR: begin
        eng_req   = 1'b1;
        eng_write = 1'b1;
        eng_addr  = IAR_ADDR;
        eng_wdata = 32'd1 << evt_id_reg;
        if (eng_done) state_next = ST_GUARD;
      end
      ST_GUARD: begin
        if (guard_cnt_reg == 4'd0) state_next = ST_IDLE;
      end
      default: state_next = ST_INIT_IER;
    endcase
  end

  always_ff @(posedge processor_clk or posedge processor_rst) begin
    if (processor_rst) begin
      evt_valid_reg <= 1'b0;
      evt_id_reg    <= '0;
      init_done_reg <= 1'b0;
      busy_reg      <= 1'b1;
      err_reg       <= 1'b0;
      guard_cnt_reg <= '0;
    end else begin
      // Rises the cycle after EMIT is entered, drops on the handshake edge.
      evt_valid_reg <= (state_reg == ST_EMIT) && !(evt_valid_reg && evt_ready);
      if (state_reg == ST_RD_IVR && eng_done && !ivr_spurious)
        evt_id_reg <= eng_rdata[4:0];
      if (state_reg == ST_INIT_MER && eng_done)
        init_done_reg <= 1'b1;
      if (eng_done && eng_resp != RESP_OKAY)
        err_reg <= 1'b1;
      busy_reg <= (state_next != ST_IDLE);
      // Loaded with N-1 on entry so exactly N edges are spent in GUARD.
      if (state_next == ST_GUARD && state_reg != ST_GUARD)
        guard_cnt_reg <= 4'(GUARD_CYCLES - 1);
      else if (state_reg == ST_GUARD && guard_cnt_reg != 4'd0)
        guard_cnt_reg <= guard_cnt_reg - 4'd1;
    end
  end

  assign evt_valid = evt_valid_reg;
  assign evt_id    = evt_id_reg;
  assign init_done = init_done_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;

`ifdef AXI_INTC_SVC_STATS_EN
  logic [31:0] svc_count_reg, spurious_count_reg;

  always_ff @(posedge processor_clk or posedge processor_rst) begin
    if (processor_rst) begin
      svc_count_reg      <= '0;
      spurious_count_reg <= '0;
    end else begin
      if (evt_valid_reg && evt_ready && svc_count_reg != 32'hFFFF_FFFF)
        svc_count_reg <= svc_count_reg + 32'd1;
      if (state_reg == ST_RD_IVR && eng_done && ivr_spurious &&
          spurious_count_reg != 32'hFFFF_FFFF)
        spurious_count_reg <= spurious_count_reg + 32'd1;
    end
  end

  assign svc_count      = svc_count_reg;
  assign spurious_count = spurious_count_reg;
`endif

endmodule

// File: tb/tb_axi_intc_servicer.sv
// Testbench for axi_intc_servicer: AXI4-Lite slave with programmable
// ready/response behaviour, randomized service sequences and a reference
// model of the expected events, acknowledges, error flag and timing.
module tb_axi_intc_servicer;

  localparam int GUARD = 3;

  logic        processor_clk = 1'b0;
  logic        processor_rst = 1'b0;
  logic [8:0]  m_axi_awaddr;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [8:0]  m_axi_araddr;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid, m_axi_rready;
  logic        irq = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [4:0]  evt_id;
  logic        init_done, busy, err;
`ifdef AXI_INTC_SVC_STATS_EN
  logic [31:0] svc_count, spurious_count;
`endif

  always #5 processor_clk = ~processor_clk;

  axi_intc_servicer #(
    .ENABLE_MASK  (32'hFFFF_FFFF),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .processor_clk (processor_clk),
    .processor_rst (processor_rst),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .irq           (irq),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_id        (evt_id),
    .init_done     (init_done),
    .busy          (busy),
    .err           (err)
`ifdef AXI_INTC_SVC_STATS_EN
    ,
    .svc_count      (svc_count),
    .spurious_count (spurious_count)
`endif
  );

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [31:0] ivr_cfg = 32'h0;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;

  int          aw_cnt, w_cnt, ar_cnt;
  logic        got_aw, got_w;
  logic [8:0]  cap_addr;
  logic [31:0] cap_data;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t wlog[$];

  logic aw_hs, w_hs;
  assign m_axi_awready = m_axi_awvalid && (aw_cnt == aw_delay);
  assign m_axi_wready  = m_axi_wvalid  && (w_cnt == w_delay);
  assign m_axi_arready = m_axi_arvalid && (ar_cnt == ar_delay);
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

  always @(posedge processor_clk or posedge processor_rst) begin
    if (processor_rst) begin
      aw_cnt       <= 0;
      w_cnt        <= 0;
      ar_cnt       <= 0;
      got_aw       <= 1'b0;
      got_w        <= 1'b0;
      cap_addr     <= '0;
      cap_data     <= '0;
      m_axi_bvalid <= 1'b0;
      m_axi_bresp  <= 2'b00;
      m_axi_rvalid <= 1'b0;
      m_axi_rresp  <= 2'b00;
      m_axi_rdata  <= '0;
    end else begin
      if (aw_hs) begin
        aw_cnt <= 0; got_aw <= 1'b1; cap_addr <= m_axi_awaddr;
      end else if (m_axi_awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin
        w_cnt <= 0; got_w <= 1'b1; cap_data <= m_axi_wdata;
      end else if (m_axi_wvalid) w_cnt <= w_cnt + 1;
      if (!m_axi_bvalid && (got_aw || aw_hs) && (got_w || w_hs)) begin
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= bresp_cfg;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0;
        got_aw       <= 1'b0;
        got_w        <= 1'b0;
        wlog.push_back('{cap_addr, cap_data});
      end
      if (m_axi_arvalid && m_axi_arready) begin
        ar_cnt       <= 0;
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= ivr_cfg;
        m_axi_rresp  <= rresp_cfg;
      end else if (m_axi_arvalid) ar_cnt <= ar_cnt + 1;
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference-model state
  logic        err_model = 1'b0;
  int          svc_model = 0;
  int          spur_model = 0;

  // One interrupt service: the model decides from the IVR value and response
  // codes what must happen, then the observed behaviour is compared.
  task automatic service(input logic [31:0] ivr, input logic [1:0] rr,
                         input logic [1:0] br, input int lag, input int wl);
    bit         spur, stable_bad, bready_bad, split_seen;
    logic [4:0] id, id_seen;
    int         n0, busy_n, evt_n, exp_busy;
    spur  = (ivr == 32'hFFFF_FFFF) || (rr != 2'b00);
    id    = 5'(ivr % 32);
    ivr_cfg = ivr; rresp_cfg = rr; bresp_cfg = br; w_delay = wl;
    n0 = wlog.size();
    stable_bad = 0; bready_bad = 0; split_seen = 0;
    busy_n = 0; evt_n = 0; id_seen = '0;
    evt_ready = (lag == 0);
    @(negedge processor_clk);
    irq = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge processor_clk); #1;
      if (c == 0) check("ar_not_yet", 32'(m_axi_arvalid), 32'd0);
      if (c == 1) begin
        check("ar_lat", 32'(m_axi_arvalid), 32'd1);
        check("ar_addr", 32'(m_axi_araddr), 32'h18);
        irq = 1'b0;   // dropping irq mid-sequence must not cut it short
      end
      if (busy) busy_n++;
      if (evt_valid) begin
        if (evt_n == 0) id_seen = evt_id;
        else if (evt_id != id_seen) stable_bad = 1;
        evt_n++;
        if (evt_n > lag) evt_ready = 1'b1;
      end
      if (m_axi_bready && m_axi_wvalid) bready_bad = 1;
      if (!m_axi_awvalid && m_axi_wvalid) split_seen = 1;
      if (!busy) break;
    end
    evt_ready = 1'b0;
    irq = 1'b0;
    check("svc_end", 32'(busy), 32'd0);

    exp_busy = spur ? 3 : 8 + GUARD + lag + wl;
    if (spur) spur_model++;
    else      svc_model++;
    err_model = err_model | (rr != 2'b00) | (!spur && br != 2'b00);

    check("busy_cycles", 32'(busy_n), 32'(exp_busy));
    check("evt_cycles", 32'(evt_n), spur ? 32'd0 : 32'(lag + 1));
    check("iar_writes", 32'(wlog.size() - n0), spur ? 32'd0 : 32'd1);
    if (!spur) begin
      check("evt_id", 32'(id_seen), 32'(id));
      check("evt_stable", 32'(stable_bad), 32'd0);
      if (wlog.size() > n0) begin
        check("iar_addr", 32'(wlog[$].addr), 32'h0C);
        check("iar_data", wlog[$].data, 32'd1 << id);
      end
      check("bready_early", 32'(bready_bad), 32'd0);
      if (wl > 0) check("aw_first", 32'(split_seen), 32'd1);
    end
    check("err", 32'(err), 32'(err_model));
`ifdef AXI_INTC_SVC_STATS_EN
    check("svc_count", svc_count, 32'(svc_model));
    check("spurious_count", spurious_count, 32'(spur_model));
`endif
    $display("svc ivr=%h rresp=%0d bresp=%0d lag=%0d wlag=%0d spurious=%0d busy=%0d evt=%0d",
             ivr, rr, br, lag, wl, spur, busy_n, evt_n);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 40) begin
      @(posedge processor_clk); #1;
      n++;
    end
    check(tag, 32'(init_done), 32'd1);
  endtask

  task automatic check_first_init_beat();
    check("rel_aw_low", 32'(m_axi_awvalid), 32'd0);
    @(posedge processor_clk); #1;
    check("rel_awvalid", 32'(m_axi_awvalid), 32'd1);
    check("rel_wvalid", 32'(m_axi_wvalid), 32'd1);
    check("rel_awaddr", 32'(m_axi_awaddr), 32'h08);
    check("rel_wdata", m_axi_wdata, 32'hFFFF_FFFF);
  endtask

  initial begin
    int n0, n;
    logic [31:0] ivr;
    logic [1:0]  rr, br;

    #2 processor_rst = 1'b1;
    repeat (3) @(posedge processor_clk);
    #1;
    check("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
    check("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("rst_bready", 32'(m_axi_bready), 32'd0);
    check("rst_rready", 32'(m_axi_rready), 32'd0);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_awaddr", 32'(m_axi_awaddr), 32'd0);
    check("rst_araddr", 32'(m_axi_araddr), 32'd0);
    check("rst_wdata", m_axi_wdata, 32'd0);
    check("rst_evt_id", 32'(evt_id), 32'd0);
    check("rst_wstrb", 32'(m_axi_wstrb), 32'hF);
    check("rst_busy", 32'(busy), 32'd1);

    @(negedge processor_clk);
    processor_rst = 1'b0;
    check_first_init_beat();
    wait_init("init_done");
    check("init_writes", 32'(wlog.size()), 32'd2);
    if (wlog.size() >= 2) begin
      check("ier_addr", 32'(wlog[0].addr), 32'h08);
      check("ier_data", wlog[0].data, 32'hFFFF_FFFF);
      check("mer_addr", 32'(wlog[1].addr), 32'h1C);
      check("mer_data", wlog[1].data, 32'h3);
    end
    check("idle_busy", 32'(busy), 32'd0);
    $display("init writes=%0d init_done=%0d", wlog.size(), init_done);

    // Directed cases
    service(32'd5, 2'b00, 2'b00, 0, 0);
    service(32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0);
    service(32'd9, 2'b00, 2'b00, 4, 3);
    service(32'd7, 2'b00, 2'b10, 0, 0);
    service(32'd31, 2'b00, 2'b00, 0, 0);
    service(32'd0, 2'b10, 2'b00, 0, 0);

    // Randomized services
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0:       ivr = 32'hFFFF_FFFF;
        1:       ivr = $urandom() & 32'hFFFF_FFFE;
        default: ivr = 32'($urandom_range(0, 31));
      endcase
      rr = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      br = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
      service(ivr, rr, br, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of an IVR read
    ar_delay = 5;
    @(negedge processor_clk);
    irq = 1'b1;
    n = 0;
    while (!m_axi_arvalid && n < 10) begin
      @(posedge processor_clk); #1;
      n++;
    end
    check("midrd_arvalid", 32'(m_axi_arvalid), 32'd1);
    #2 processor_rst = 1'b1;
    #1;
    irq = 1'b0;
    check("async_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("async_rready", 32'(m_axi_rready), 32'd0);
    check("async_init_done", 32'(init_done), 32'd0);
    check("async_err", 32'(err), 32'd0);
    check("async_busy", 32'(busy), 32'd1);
    err_model = 1'b0; svc_model = 0; spur_model = 0;
    ar_delay = 0;
`ifdef AXI_INTC_SVC_STATS_EN
    check("rst_svc_count", svc_count, 32'd0);
    check("rst_spurious_count", spurious_count, 32'd0);
`endif
    repeat (2) @(posedge processor_clk);
    n0 = wlog.size();
    @(negedge processor_clk);
    processor_rst = 1'b0;
    check_first_init_beat();
    wait_init("reinit_done");
    check("reinit_writes", 32'(wlog.size() - n0), 32'd2);
    if (wlog.size() >= n0 + 2)
      check("reinit_mer", 32'(wlog[$].addr), 32'h1C);
    $display("reinit writes=%0d init_done=%0d", wlog.size() - n0, init_done);
    service(32'd3, 2'b00, 2'b00, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_intc_servicer.md
# axi_intc_servicer

AXI4-Lite initiator that drives the AXI interrupt controller's register slave from the processor side. After reset it programs IER and MER. It then services each level `irq` by reading IVR, handing the decoded interrupt ID to a downstream consumer, and writing IAR to acknowledge. It sits between the interrupt controller's 9-bit AXI4-Lite slave port and the processor-side logic, and replaces software interrupt handling in hardware-only test systems.

## Interface
- `ENABLE_MASK`, default 32'hFFFF_FFFF: value written to IER during init.
- `GUARD_CYCLES`, default 2: idle cycles after an IAR write completes before `irq` is sampled again; legal range 1..15.
- `processor_clk` in 1: single clock; every port is synchronous to it, including `irq`.
- `processor_rst` in 1: asynchronous, active-high reset.
- `m_axi_awaddr` out 9, `m_axi_awvalid` out 1, `m_axi_awready` in 1: write address channel.
- `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wvalid` out 1, `m_axi_wready` in 1: write data channel.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1: write response channel.
- `m_axi_araddr` out 9, `m_axi_arvalid` out 1, `m_axi_arready` in 1: read address channel.
- `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1: read data channel.
- `irq` in 1: level interrupt from the controller.
- `evt_valid` out 1, `evt_ready` in 1, `evt_id` out 5: serviced-interrupt handshake.
- `init_done` out 1: high once MER has been written.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky flag; set on any BRESP or RRESP other than OKAY.

## Operation
- Register offsets: IER 0x08, IAR 0x0C, IVR 0x18, MER 0x1C.
- `wstrb` is always 4'hF. One transaction is outstanding at a time.
- States:
  - INIT_IER: write ENABLE_MASK to 0x08.
  - INIT_MER: write 0x3 to 0x1C; `init_done` goes high on its B response.
  - IDLE: wait for `irq`=1.
  - RD_IVR: read 0x18.
  - EMIT: present the ID on the event handshake.
  - WR_IAR: write (1 << id) to 0x0C.
  - GUARD: count GUARD_CYCLES, then return to IDLE.
- Write states:
  - Assert AW and W together with the same address and data.
  - Deassert each valid independently on its own handshake.
  - Raise `bready` once both handshakes are done.
  - Leave the state on `bvalid`&`bready`.
- Read state: assert `arvalid` until `arready`. Then hold `rready`=1 until `rvalid`.
- IVR decode:
  - `rdata`=32'hFFFF_FFFF, or RRESP≠OKAY: spurious. Go to IDLE; no event, no IAR write.
  - Otherwise `evt_id`=`rdata[4:0]` and go to EMIT.
- EMIT: `evt_valid` stays high with `evt_id` stable until `evt_ready`, then go to WR_IAR.
- Error response in an init or IAR write: set `err` and still advance.
- `irq` deasserting after RD_IVR has started has no effect; the sequence completes.
- Reset (async) mid-transaction: all valids and readies drop immediately, the FSM returns to INIT_IER, and the stats counters clear. Re-init happens on release.

## Timing
- Reset values:
  - All `*valid`, `bready`, `rready`, `evt_valid`, `init_done`, `err`: 0.
  - `awaddr`, `araddr`, `wdata`, `evt_id`: 0.
  - `wstrb`: 4'hF.
  - `busy`: 1.
- All outputs are registered.
- First cycle after reset release: `awvalid`=`wvalid`=1 with addr 0x08.
- `irq`=1 sampled in IDLE at edge N: `arvalid`=1 with addr 0x18 from edge N+1.
- Accepted R beat at edge M: `evt_valid`=1 from M+1.
- `evt_ready` at edge K: `awvalid`/`wvalid`=1 from K+1.
- Zero-wait slave, full service sequence: IDLE→IDLE in 8+GUARD_CYCLES cycles.
- Simultaneous `awready`/`wready` in the same cycle: both valids drop at the next edge.

## Configuration
- Macro `AXI_INTC_SVC_STATS_EN`. Defined: adds these 32-bit saturating outputs:
  - `svc_count`: increments on each EMIT handshake.
  - `spurious_count`: increments on each spurious IVR.

  Both reset to 0 and hold at 32'hFFFF_FFFF.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Package `axi_intc_svc_pkg`: register offset localparams, AXI resp codes (OKAY=2'b00), state enum, and the IVR-none constant 32'hFFFF_FFFF.
- One sub-module, `axi_lite_single_master`: a single-beat read/write engine with req/done/resp/rdata. The top-level FSM sequences it.

## Test plan
- Reset release, zero-wait slave: writes 0x08←0xFFFF_FFFF then 0x1C←0x3; `init_done`=1 after the second B response.
- `irq`=1, IVR returns 5, `evt_ready` tied 1: `evt_id`=5 pulses for one cycle, then write 0x0C←0x20, then GUARD, then IDLE.
- IVR returns 0xFFFF_FFFF: no event and no AW; back to IDLE (with stats: `spurious_count`=1).
- `wready` delayed 3 cycles after `awready`: `awvalid` drops first, `wvalid` holds, `bready` rises only after W is accepted; `evt_ready` held low 4 cycles keeps `evt_id` stable.
- BRESP=2'b10 on the IAR write: `err`=1 and stays set; the next `irq` is still serviced.
- `processor_rst` asserted mid RD_IVR: `arvalid`/`rready` drop asynchronously and the init sequence restarts after release.
